// File: rtl/video_timing_if.sv
// Pixel-side bundle for the raster generator.
//   master (video_timing): drives xp/yp/writable, VGA pins and frame events;
//                          samples fg/bg colours for the current xp/yp.
//   slave  (stages/board): the reverse view.
interface video_timing_if;
  logic [7:0] xp;
  logic [7:0] yp;
  logic       writable;
  logic [1:0] fg_r;
  logic [1:0] fg_g;
  logic [1:0] fg_b;
  logic       fg_valid;
  logic [1:0] bg_r;
  logic [1:0] bg_g;
  logic [1:0] bg_b;
  logic [1:0] vga_r;
  logic [1:0] vga_g;
  logic [1:0] vga_b;
  logic       vga_hsync;
  logic       vga_vsync;
  logic       frame_start;
  logic [7:0] frame_count;

  modport master (
    output xp, yp, writable,
    output vga_r, vga_g, vga_b, vga_hsync, vga_vsync,
    output frame_start, frame_count,
    input  fg_r, fg_g, fg_b, fg_valid,
    input  bg_r, bg_g, bg_b
  );

  modport slave (
    input  xp, yp, writable,
    input  vga_r, vga_g, vga_b, vga_hsync, vga_vsync,
    input  frame_start, frame_count,
    output fg_r, fg_g, fg_b, fg_valid,
    output bg_r, bg_g, bg_b
  );
endinterface

// File: rtl/video_timing.sv
// Free-running 640x480@60 raster generator at half pixel rate (one clk = two
// VGA pixels). Drives game coordinates xp/yp and the VRAM writable window,
// composites foreground over background into registered VGA colour/syncs,
// and reports a per-frame pulse plus a wrapping frame counter.
// Ports:
//   clk  - pixel clock (12.5875 MHz)
//   rst  - asynchronous, active-low reset
//   vt   - video_timing_if.master (coordinates, colours, VGA pins, frame events)
module video_timing #(
  parameter int unsigned H_VISIBLE = 320,
  parameter int unsigned H_FRONT   = 8,
  parameter int unsigned H_SYNC    = 48,
  parameter int unsigned H_BACK    = 24,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33,
  parameter int unsigned H_BORDER  = 32
) (
  input logic            clk,
  input logic            rst,
  video_timing_if.master vt
);

  localparam int unsigned H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam logic [8:0]  H_LAST    = 9'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [8:0]  HS_START  = 9'(H_VISIBLE + H_FRONT);
  localparam logic [8:0]  HS_END    = 9'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0]  VS_START  = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0]  VS_END    = 10'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [8:0]  GAME_LO   = 9'(H_BORDER);
  localparam logic [8:0]  GAME_HI   = 9'(H_BORDER + 256);
  localparam logic [8:0]  H_VIS     = 9'(H_VISIBLE);
  localparam logic [9:0]  V_VIS     = 10'(V_VISIBLE);
  localparam logic [7:0]  XP_RESET  = 8'(9'd0 - GAME_LO);

  logic [8:0] hc_q, hc_d;
  logic [9:0] vc_q, vc_d;
  logic [7:0] xp_q, xp_d;
  logic [7:0] yp_q, yp_d;
  logic       writable_q, writable_d;
  logic [5:0] rgb_q, rgb_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       frame_start_q, frame_start_d;
  logic [7:0] frame_count_q, frame_count_d;
  logic       active_c, game_c, hs_c, vs_c;

  // Raster counters and frame events; xp/yp/writable are registered from the
  // next counter values so they always equal the decode of hc_q/vc_q.
  always_comb begin
    hc_d          = hc_q + 9'd1;
    vc_d          = vc_q;
    frame_start_d = 1'b0;
    frame_count_d = frame_count_q;
    if (hc_q == H_LAST) begin
      hc_d = '0;
      if (vc_q == V_LAST) begin
        vc_d          = '0;
        frame_start_d = 1'b1;
        frame_count_d = frame_count_q + 8'd1;
      end else begin
        vc_d = vc_q + 10'd1;
      end
    end
    xp_d       = 8'(hc_d - GAME_LO);
    yp_d       = vc_d[8:1];
    writable_d = (vc_d >= V_VIS);
  end

  // Region decodes for the current counter state.
  always_comb begin
    active_c = (hc_q < H_VIS) && (vc_q < V_VIS);
    game_c   = active_c && (hc_q >= GAME_LO) && (hc_q < GAME_HI);
    hs_c     = (hc_q >= HS_START) && (hc_q < HS_END);
    vs_c     = (vc_q >= VS_START) && (vc_q < VS_END);
  end

  // Compositor: borders and blanking are black, opaque foreground wins.
  always_comb begin
    rgb_d   = '0;
    hsync_d = !hs_c;
    vsync_d = !vs_c;
    if (game_c) begin
      if (vt.fg_valid) rgb_d = {vt.fg_r, vt.fg_g, vt.fg_b};
      else             rgb_d = {vt.bg_r, vt.bg_g, vt.bg_b};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hc_q          <= '0;
      vc_q          <= '0;
      xp_q          <= XP_RESET;
      yp_q          <= '0;
      writable_q    <= 1'b0;
      rgb_q         <= '0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      frame_start_q <= 1'b0;
      frame_count_q <= '0;
    end else begin
      hc_q          <= hc_d;
      vc_q          <= vc_d;
      xp_q          <= xp_d;
      yp_q          <= yp_d;
      writable_q    <= writable_d;
      rgb_q         <= rgb_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      frame_start_q <= frame_start_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign vt.xp          = xp_q;
  assign vt.yp          = yp_q;
  assign vt.writable    = writable_q;
  assign vt.vga_r       = rgb_q[5:4];
  assign vt.vga_g       = rgb_q[3:2];
  assign vt.vga_b       = rgb_q[1:0];
  assign vt.vga_hsync   = hsync_q;
  assign vt.vga_vsync   = vsync_q;
  assign vt.frame_start = frame_start_q;
  assign vt.frame_count = frame_count_q;

endmodule

// File: doc/video_timing.md
Name: video_timing

Overview:
- Free-running 640x480@60 Hz raster generator for the reduced GPU. It runs at half pixel rate (12.5875 MHz), so one clk covers two VGA pixels.
- Drives the game-pixel coordinates xp/yp and the VRAM `writable` window into the background and foreground stages.
- Composites their same-cycle combinational colour outputs (foreground over background) into registered VGA r/g/b plus hsync/vsync, all aligned.
- Also provides a per-frame pulse and a frame counter for the CPU interface.

Parameters:
- H_VISIBLE, 320: visible clks per line.
- H_FRONT, 8: horizontal front-porch clks.
- H_SYNC, 48: hsync-width clks.
- H_BACK, 24: horizontal back-porch clks (line total 400).
- V_VISIBLE, 480: visible lines.
- V_FRONT, 10: vertical front-porch lines.
- V_SYNC, 2: vsync-width lines.
- V_BACK, 33: vertical back-porch lines (frame total 525).
- H_BORDER, 32: blank clks left of the 256-wide game area.

Ports:
- clk  in  1  pixel clock, 12.5875 MHz
- rst  in  1  asynchronous, active-low reset
- xp  out  8  game x coordinate = (hc - H_BORDER) mod 256
- yp  out  8  game y coordinate = vc[8:1]
- writable  out  1  VRAM write window; high during vertical blanking
- fg_r, fg_g, fg_b  in  2 each  foreground colour for the current xp/yp
- fg_valid  in  1  foreground pixel is opaque
- bg_r, bg_g, bg_b  in  2 each  background colour for the current xp/yp
- vga_r, vga_g, vga_b  out  2 each  registered output colour
- vga_hsync, vga_vsync  out  1 each  registered syncs, active-low
- frame_start  out  1  one-clk pulse at the start of each frame
- frame_count  out  8  frames completed, wraps modulo 256

Behaviour:
- Counters:
  - hc is 9-bit, counts 0..399.
  - vc is 10-bit, counts 0..524.
  - hc increments every clk. At 399, hc wraps to 0 and vc increments.
  - At hc=399 and vc=524, both wrap to 0 together.
- Reset (rst=0, asynchronous, any time including mid-line):
  - hc=0, vc=0.
  - vga_r/g/b=0; vga_hsync=1; vga_vsync=1.
  - frame_start=0; frame_count=0.
  - Hence xp=8'hE0, yp=0, writable=0.
  - After rst deasserts, the first active edge moves hc to 1. No partial-frame state survives.
- xp, yp and writable are pure decodes of the hc/vc registers: no combinational input paths, glitch-free.
  - xp = (hc - H_BORDER)[7:0].
  - yp = vc[8:1], so each game line is displayed twice.
  - writable = (vc >= V_VISIBLE). It rises at the first clk of line 480 and falls when vc wraps to 0.
- Region decodes, from the current hc/vc:
  - active = (hc < H_VISIBLE) && (vc < V_VISIBLE).
  - game = active && (hc >= H_BORDER) && (hc < H_BORDER+256).
  - hs = H_VISIBLE+H_FRONT <= hc < H_VISIBLE+H_FRONT+H_SYNC, i.e. hc 328..375.
  - vs = V_VISIBLE+V_FRONT <= vc < V_VISIBLE+V_FRONT+V_SYNC, i.e. vc 490..491.
- Compositor, latency exactly 1 clk from the counter state to the VGA pins:
  - If !active: vga_rgb <= 0.
  - Else if !game (side border): vga_rgb <= 0.
  - Else if fg_valid: vga_rgb <= fg_rgb.
  - Else: vga_rgb <= bg_rgb.
  - vga_hsync <= !hs and vga_vsync <= !vs, registered in the same edge so syncs stay aligned with colour.
- fg/bg inputs are sampled in the cycle whose hc/vc generated xp/yp. Both upstream stages must be purely combinational from xp/yp.
- Frame events:
  - frame_start is registered. It is 1 for exactly the clk after the counters wrap to hc=0, vc=0; never asserted by reset itself.
  - frame_count increments on that same edge and wraps 255 -> 0.
- xp wraps in the borders: hc 288..319 give xp 0..31. Such pixels are forced black by `game`, but xp still toggles. Downstream must not treat xp alone as "on screen".

Test Plan:
- Reset/free-run: assert rst=0 mid-line at hc=150, release, run 2 frames.
  - During reset: outputs at reset values.
  - Count clks between falling vga_hsync edges = 400.
  - Count clks between falling vga_vsync edges = 210000.
  - vga_hsync low for 48 clks; vga_vsync low for 800 clks.
- Coordinates: at hc=32, vc=0 -> xp=0, yp=0; at hc=287, vc=3 -> xp=255, yp=1; at hc=0 -> xp=8'hE0.
- Compositor priority, at hc=100, vc=100:
  - fg_valid=1, fg=3/0/1, bg=2/2/2 -> next clk vga=3/0/1.
  - fg_valid=0 -> vga=2/2/2.
  - At hc=10 (border), same inputs -> vga=0/0/0.
  - At hc=330 -> vga=0/0/0 with vga_hsync=0 on that output clk.
- Writable window: writable=0 at vc=479 hc=399; =1 at vc=480 hc=0; stays 1 through vc=524 hc=399; =0 at vc=0 hc=0.
- Frame counter: run 257 frames -> 257 single-clk frame_start pulses, each the clk after the wrap; frame_count ends at 1 after passing 255->0.
- Alignment: drive fg_valid=1 only when xp==0 and yp==0, fg=3/3/3 -> the single white output pixel appears at the clk after hc=32, vc=0 and again after hc=32, vc=1.
